// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Package : conv_pkg
//  Shared defaults, sum-width helper and result entry type for the
//  convolution sum collector.
//  Revision: 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int DEFAULT_BITWIDTH     = 8;
    localparam int DEFAULT_FILTER_WIDTH = 3;
    localparam int DEFAULT_IMAGE_WIDTH  = 11;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

    // Width that holds the sum of fw*fw unsigned bw-bit values without wrap
    function automatic int sum_width(input int bw, input int fw);
        return bw + $clog2(fw * fw);
    endfunction

    localparam int DEFAULT_SUM_WIDTH = sum_width(DEFAULT_BITWIDTH, DEFAULT_FILTER_WIDTH);

    typedef struct packed {
        logic [DEFAULT_SUM_WIDTH-1:0] sum;
        logic                         lastInRow;
        logic                         lastInFrame;
    } result_entry_t;

endpackage
`default_nettype wire

// File: rtl/conv_sum_collector_if.sv
`default_nettype none
// ============================================================================
//  Interface : conv_sum_collector_if
//  Product input and result output stream of the convolution sum collector.
//  Revision: 1.0 - initial release
// ============================================================================
interface conv_sum_collector_if
    import conv_pkg::*;
#(
    parameter int bitwidth    = DEFAULT_BITWIDTH,
    parameter int filterWidth = DEFAULT_FILTER_WIDTH,
    parameter int imageWidth  = DEFAULT_IMAGE_WIDTH
);
    localparam int sumWidth = sum_width(bitwidth, filterWidth);

    logic [filterWidth-1:0][0:filterWidth-1][bitwidth-1:0] products_in;
    logic                products_dummy_unused_guard;
    logic                productsReady_in;
    logic [sumWidth-1:0] result_out;
    logic                resultValid_out;
    logic                resultReady_in;
    logic                lastInRow_out;
    logic                lastInFrame_out;
    logic                overflow_out;

    assign products_dummy_unused_guard = 1'b0;

    // Upstream producer / downstream consumer side
    modport master (
        output products_in, productsReady_in, resultReady_in,
        input  result_out, resultValid_out, lastInRow_out, lastInFrame_out, overflow_out
    );

    // Collector side
    modport slave (
        input  products_in, productsReady_in, resultReady_in,
        output result_out, resultValid_out, lastInRow_out, lastInFrame_out, overflow_out
    );

endinterface
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : result_fifo
//  Synchronous FIFO with asynchronous reset; write accepted when not full or
//  when a read happens in the same cycle.
//  Revision: 1.0 - initial release
// ============================================================================
module result_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             rd_en,
    output logic      [WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);
    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w:0] r_wr_ptr;
    logic [c_ptr_w:0] r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_pop   = rd_en && !empty;
    // A pop in the same cycle frees the slot the push needs
    assign w_push  = wr_en && (!full || w_pop);
    assign rd_data = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_ptr_w-1:0]] <= wr_data;
                r_wr_ptr <= r_wr_ptr + (c_ptr_w+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_ptr_w+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_sum_collector.sv
`default_nettype none
// ============================================================================
//  Module  : conv_sum_collector
//  Two-stage adder tree over the product window, output position tagging and
//  buffered valid/ready result stream.
//  Revision: 1.0 - initial release
// ============================================================================
module conv_sum_collector
    import conv_pkg::*;
#(
    parameter int bitwidth    = DEFAULT_BITWIDTH,
    parameter int filterWidth = DEFAULT_FILTER_WIDTH,
    parameter int imageWidth  = DEFAULT_IMAGE_WIDTH,
    parameter int fifoDepth   = DEFAULT_FIFO_DEPTH
) (
    input  wire logic            clock,
    input  wire logic            reset,
    conv_sum_collector_if.slave  bus
);
    localparam int filterSize = filterWidth * filterWidth;
    localparam int sumWidth   = bitwidth + $clog2(filterSize);
    localparam int outWidth   = imageWidth - filterWidth + 1;
    localparam int rowWidth   = bitwidth + $clog2(filterWidth);
    localparam int cntWidth   = (outWidth > 1) ? $clog2(outWidth) : 1;
    localparam logic [cntWidth-1:0] c_pos_last = cntWidth'(outWidth - 1);

    typedef struct packed {
        logic [sumWidth-1:0] sum;
        logic                lastInRow;
        logic                lastInFrame;
    } entry_t;

    logic [filterWidth-1:0][rowWidth-1:0] w_row_sum;
    logic [filterWidth-1:0][rowWidth-1:0] r_row_sum;
    logic [sumWidth-1:0]                  w_total;
    logic                                 r_s1_valid;
    logic                                 r_s1_last_row;
    logic                                 r_s1_last_frame;
    logic [cntWidth-1:0]                  r_col;
    logic [cntWidth-1:0]                  r_row;
    logic                                 w_last_col;
    logic                                 r_s2_valid;
    entry_t                               r_s2_entry;
    entry_t                               w_head;
    logic                                 w_full;
    logic                                 w_empty;
    logic                                 w_rd_en;
    logic                                 w_drop;
    logic                                 r_overflow;

    always_comb begin
        w_row_sum = '0;
        for (int r = 0; r < filterWidth; r++) begin
            for (int c = 0; c < filterWidth; c++) begin
                w_row_sum[r] = w_row_sum[r] + rowWidth'(bus.products_in[r][c]);
            end
        end
    end

    always_comb begin
        w_total = '0;
        for (int r = 0; r < filterWidth; r++) begin
            w_total = w_total + sumWidth'(r_row_sum[r]);
        end
    end

    assign w_last_col = (r_col == c_pos_last);

    // Stage 1: row sums, position tags and output-map position counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid      <= 1'b0;
            r_row_sum       <= '0;
            r_s1_last_row   <= 1'b0;
            r_s1_last_frame <= 1'b0;
            r_col           <= '0;
            r_row           <= '0;
        end else begin
            r_s1_valid <= bus.productsReady_in;
            if (bus.productsReady_in) begin
                r_row_sum       <= w_row_sum;
                r_s1_last_row   <= w_last_col;
                r_s1_last_frame <= w_last_col && (r_row == c_pos_last);
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= (r_row == c_pos_last) ? '0 : r_row + cntWidth'(1);
                end else begin
                    r_col <= r_col + cntWidth'(1);
                end
            end
        end
    end

    // Stage 2: full-width window total
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_entry <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_entry <= '{sum: w_total, lastInRow: r_s1_last_row,
                                lastInFrame: r_s1_last_frame};
            end
        end
    end

    assign w_rd_en = !w_empty && bus.resultReady_in;
    assign w_drop  = r_s2_valid && w_full && !w_rd_en;

    result_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (fifoDepth)
    ) u_result_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (r_s2_valid),
        .wr_data (r_s2_entry),
        .rd_en   (w_rd_en),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Head fields are forced to zero while nothing is buffered
    assign bus.resultValid_out = !w_empty;
    assign bus.result_out      = w_empty ? '0 : w_head.sum;
    assign bus.lastInRow_out   = !w_empty && w_head.lastInRow;
    assign bus.lastInFrame_out = !w_empty && w_head.lastInFrame;
    assign bus.overflow_out    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_conv_sum_collector.sv
`default_nettype none
// ============================================================================
//  Module  : tb_conv_sum_collector
//  Scoreboard bench: stimulus pushes expected results, a monitor pops them on
//  every output handshake.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_conv_sum_collector;
    import conv_pkg::*;

    typedef logic [2:0][0:2][7:0] prod_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [13:0] sb [$];
    int   m_col = 0;
    int   m_row = 0;

    conv_sum_collector_if #(.bitwidth(8), .filterWidth(3), .imageWidth(11)) bus ();

    conv_sum_collector #(
        .bitwidth    (8),
        .filterWidth (3),
        .imageWidth  (11),
        .fifoDepth   (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic prod_t fill(input int v);
        prod_t p;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = v[7:0];
        return p;
    endfunction

    // Called at posedge+1; drives one pulse for one cycle
    task automatic send(input prod_t p, input int exp_sum, input bit drop);
        logic lr, lf;
        lr = (m_col == 8);
        lf = lr && (m_row == 8);
        if (!drop) sb.push_back({exp_sum[11:0], lr, lf});
        if (lr) begin
            m_col = 0;
            m_row = (m_row == 8) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
        bus.products_in      = p;
        bus.productsReady_in = 1'b1;
        @(posedge clock);
        #1;
        bus.productsReady_in = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        sb.delete();
        m_col = 0;
        m_row = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || bus.resultValid_out) && k < 200) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("drain_timeout", (k >= 200) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Monitor: compare the head against the scoreboard on every handshake
    always @(negedge clock) begin
        if (!reset && bus.resultValid_out && bus.resultReady_in) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d with empty scoreboard", bus.result_out);
            end else begin
                logic [13:0] e;
                e = sb.pop_front();
                check("result_sum", 32'(bus.result_out), 32'(e[13:2]));
                check("lastInRow", 32'(bus.lastInRow_out), 32'(e[1]));
                check("lastInFrame", 32'(bus.lastInFrame_out), 32'(e[0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        prod_t seq;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                seq[r][c] = 8'(r * 3 + c + 1);

        bus.products_in      = '0;
        bus.productsReady_in = 1'b0;
        bus.resultReady_in   = 1'b0;
        reset                = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_result", 32'(bus.result_out), 0);
        check("rst_valid", 32'(bus.resultValid_out), 0);
        check("rst_lastInRow", 32'(bus.lastInRow_out), 0);
        check("rst_lastInFrame", 32'(bus.lastInFrame_out), 0);
        check("rst_overflow", 32'(bus.overflow_out), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single window 1..9 and latency
        bus.resultReady_in = 1'b1;
        send(seq, 45, 1'b0);
        check("lat_e0_valid", 32'(bus.resultValid_out), 0);
        @(posedge clock); #1;
        check("lat_e1_valid", 32'(bus.resultValid_out), 0);
        @(posedge clock); #1;
        check("lat_e2_valid", 32'(bus.resultValid_out), 1);
        check("lat_e2_sum", 32'(bus.result_out), 45);
        check("lat_e2_lastInRow", 32'(bus.lastInRow_out), 0);
        wait_drain();

        // All products at maximum value
        send(fill(255), 2295, 1'b0);
        wait_drain();

        // Full frame plus one, back to back
        apply_reset();
        bus.resultReady_in = 1'b1;
        for (int i = 1; i <= 82; i++) send(fill(i % 28), 9 * (i % 28), 1'b0);
        wait_drain();

        // Overflow with consumer stalled
        apply_reset();
        bus.resultReady_in = 1'b0;
        for (int i = 1; i <= 5; i++) send(fill(i), 9 * i, (i == 5));
        check("ovf_e0", 32'(bus.overflow_out), 0);
        @(posedge clock); #1;
        check("ovf_e1", 32'(bus.overflow_out), 0);
        @(posedge clock); #1;
        check("ovf_e2", 32'(bus.overflow_out), 1);
        check("ovf_head", 32'(bus.result_out), 9);
        bus.resultReady_in = 1'b1;
        wait_drain();
        repeat (3) @(posedge clock);
        #1;
        check("ovf_no_extra", 32'(bus.resultValid_out), 0);
        check("ovf_sticky", 32'(bus.overflow_out), 1);

        // Full FIFO with read on the write cycle
        apply_reset();
        bus.resultReady_in = 1'b0;
        for (int i = 10; i <= 13; i++) send(fill(i), 9 * i, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        send(fill(20), 180, 1'b0);
        @(posedge clock); #1;
        bus.resultReady_in = 1'b1;
        @(posedge clock); #1;
        bus.resultReady_in = 1'b0;
        check("full_rw_overflow", 32'(bus.overflow_out), 0);
        check("full_rw_head", 32'(bus.result_out), 99);
        bus.resultReady_in = 1'b1;
        wait_drain();
        check("full_rw_overflow_end", 32'(bus.overflow_out), 0);

        // Reset mid-frame with entries buffered
        apply_reset();
        bus.resultReady_in = 1'b1;
        for (int i = 1; i <= 3; i++) send(fill(i), 9 * i, 1'b0);
        wait_drain();
        bus.resultReady_in = 1'b0;
        for (int i = 4; i <= 5; i++) send(fill(i), 9 * i, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("pre_rst_valid", 32'(bus.resultValid_out), 1);
        #1;
        reset = 1'b1;
        sb.delete();
        m_col = 0;
        m_row = 0;
        #1;
        check("mid_rst_result", 32'(bus.result_out), 0);
        check("mid_rst_valid", 32'(bus.resultValid_out), 0);
        check("mid_rst_lastInRow", 32'(bus.lastInRow_out), 0);
        check("mid_rst_lastInFrame", 32'(bus.lastInFrame_out), 0);
        check("mid_rst_overflow", 32'(bus.overflow_out), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.resultReady_in = 1'b1;
        for (int i = 1; i <= 9; i++) send(fill(6), 54, 1'b0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_sum_collector.md
# conv_sum_collector

Receiving end of the convolution module's product interface. Samples the filterWidth×filterWidth product array whenever the ready pulse is high, reduces it in a two-stage pipelined adder tree and tags each sum with its output-map position. Results are buffered in a small FIFO and presented on a valid/ready stream to the next layer. Sits directly downstream of the convolution module, once per filter.

## Interface
- bitwidth, 8: width of each product element (unsigned).
- filterWidth, 3: filter edge length; the product array is filterWidth×filterWidth.
- imageWidth, 11: input image edge length.
- fifoDepth, 4: output FIFO entries (power of 2, ≥2).
- Derived (localparam): filterSize = filterWidth², sumWidth = bitwidth + $clog2(filterSize), outWidth = imageWidth − filterWidth + 1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- products_in  in  bitwidth × [filterWidth-1:0][0:filterWidth-1]  product array from the convolution module.
- productsReady_in  in  1  one cycle high per window; products_in valid that cycle.
- result_out  out  sumWidth  sum of one window (FIFO head).
- resultValid_out  out  1  FIFO non-empty.
- resultReady_in  in  1  consumer accepts the head when high together with valid.
- lastInRow_out  out  1  head is the last column of an output row.
- lastInFrame_out  out  1  head is the final result of the frame.
- overflow_out  out  1  sticky: at least one result was dropped.

## Operation
- Input side has no backpressure; every productsReady_in pulse is consumed.
- Stage 1, at the edge where productsReady_in=1: register filterWidth row sums (each of width bitwidth + $clog2(filterWidth)), plus a stage valid flag and position tags.
- Stage 2: register the total of the row sums at full sumWidth. No truncation, no saturation; all arithmetic is unsigned.
- Position counters col and row, each 0..outWidth−1, advance on every accepted pulse. col wraps to 0 after outWidth−1 and increments row at that point. row wraps to 0 after the last column of row outWidth−1.
- Tags are captured at stage 1: lastInRow = (col == outWidth−1); lastInFrame = lastInRow && (row == outWidth−1).
- FIFO write: stage 2 valid writes {sum, lastInRow, lastInFrame}.
- If the FIFO is full and no read occurs that cycle, the entry is dropped and overflow_out is set until reset.
- Counters still advance on dropped entries, so the tags of later results stay aligned.
- FIFO read: a handshake (resultValid_out && resultReady_in) pops the head.

## Timing
- Reset values: result_out=0, resultValid_out=0, lastInRow_out=0, lastInFrame_out=0, overflow_out=0. Pipeline valids, FIFO pointers and counters are all 0.
- Latency: a pulse sampled at edge E0 gives stage 2 at E1 and the FIFO write at E2. resultValid_out is high after E2 when the FIFO was empty. There is no bypass.
- Throughput: one result per cycle (back-to-back pulses are legal).
- Simultaneous write and read while full: the write is accepted, the occupancy is unchanged, and overflow_out is not set.
- Simultaneous write and read while holding one entry: the head pops and the new entry becomes the head next cycle; valid stays high.
- Outputs are stable while resultValid_out=1 and resultReady_in=0.
- Reset asserted mid-frame: in-flight stage data and the FIFO contents are discarded immediately (asynchronously). After release, the next pulse is treated as col=0, row=0.

## Structure
- conv_pkg: default bitwidth/filterWidth/imageWidth, a sum-width helper function, and the result entry struct {sum, lastInRow, lastInFrame} (parameterised by width via the helper).
- Sub-module result_fifo: synchronous FIFO with async reset, fifoDepth entries, wr_en/rd_en/full/empty.
- Adder tree and position counters stay in the top module.

## Test plan
- Single window with products 1..9 (bitwidth 8, filterWidth 3): result_out=45 with resultValid_out rising 3 edges after the pulse, and lastInRow_out=0.
- All products 255: result_out=2295, and sumWidth=12 with no wrap.
- 81 consecutive pulses with imageWidth 11 and ready held high: lastInRow_out on results 9, 18, …, 81; lastInFrame_out only on result 81; the 82nd result has both tags 0.
- resultReady_in held low, 5 pulses: 4 entries held in order and the 5th dropped. overflow_out=1 from 2 edges after the 5th pulse; draining then yields exactly 4 results.
- FIFO full and a pulse arriving while resultReady_in=1 on the write cycle: no drop, overflow_out stays 0, and the order is preserved.
- Reset pulsed after 5 pulses with 2 results in the FIFO: all outputs are 0 immediately. The next 9 pulses give lastInRow_out on the 9th result.
